cadence_meas: RTL and testbench

- Front end that produces the `cadence` and `not_pedaling` inputs consumed by the desired-drive pipeline.
- Takes the raw, asynchronous crank cadence sensor, synchronizes and glitch-filters it, and counts rising edges per fixed window to produce a 5-bit saturating cadence.
- Flags a stall when no edge arrives within a timeout.
- Emits a one-cycle `cadence_rise` strobe for the torque-averaging logic.

---
 rtl/cadence_meas.sv | 110 +++++++++++
 tb/tb_cadence_meas.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cadence_meas.sv
// Crank cadence front end: synchronizer, glitch filter, windowed edge count and stall flag.
// Define CADENCE_IIR_EN to smooth cadence with a 3/4-weight IIR on each window end.
`timescale 1ns/1ps
module cadence_meas #(
  parameter int FILT_CYC = 16,
  parameter int WIN_W    = 24,
  parameter int STALL_W  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cadence_raw,
  output logic       cadence_rise,
  output logic [4:0] cadence,
  output logic       not_pedaling
);
  localparam int FC_W = $clog2(FILT_CYC + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic               sync_a;
  logic               synced;
  logic               filt;
  logic [FC_W-1:0]    filt_cnt;
  logic               filt_take;
  logic               rise_next;
  logic [WIN_W-1:0]   win_cnt;
  logic               win_end;
  logic [4:0]         edge_cnt;
  logic [4:0]         new_count;
  logic [4:0]         cad_next;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_next;
  logic               np_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      synced <= 1'b0;
    end else begin
      sync_a <= cadence_raw;
      synced <= sync_a;
    end
  end

  // filt follows only after FILT_CYC consecutive differing samples
  assign filt_take = (synced != filt) && (filt_cnt == FC_LAST);
  assign rise_next = filt_take && synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt         <= 1'b0;
      filt_cnt     <= '0;
      cadence_rise <= 1'b0;
    end else begin
      cadence_rise <= rise_next;
      if (synced == filt) begin
        filt_cnt <= '0;
      end else if (filt_take) begin
        filt     <= synced;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // A rise present on the terminal cycle belongs to the closing window
  assign win_end   = &win_cnt;
  assign new_count = (cadence_rise && (edge_cnt != 5'd31)) ? edge_cnt + 5'd1 : edge_cnt;

`ifdef CADENCE_IIR_EN
  logic [6:0] iir_sum;
  assign iir_sum  = ({2'b00, cadence} * 7'd3) + {2'b00, new_count};
  assign cad_next = iir_sum[6:2];
`else
  assign cad_next = new_count;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      cadence  <= '0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (win_end) begin
        edge_cnt <= '0;
        cadence  <= cad_next;
      end else begin
        edge_cnt <= new_count;
      end
    end
  end

  // not_pedaling holds from reset until the first rise, then tracks stall saturation
  assign stall_next = cadence_rise ? '0 :
                      (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
  assign np_next    = (not_pedaling && !cadence_rise) || (stall_next == STALL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      not_pedaling <= 1'b1;
    end else begin
      stall_cnt    <= stall_next;
      not_pedaling <= np_next;
    end
  end

endmodule

// File: tb/tb_cadence_meas.sv
// Scoreboard bench for cadence_meas: waveform-level model predicts rises, window counts
// and stall flag edges; a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_cadence_meas;
  localparam int F         = 4;
  localparam int WIN       = 256;
  localparam int STALL_CYC = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cadence_raw = 1'b0;
  logic       cadence_rise;
  logic [4:0] cadence;
  logic       not_pedaling;

  cadence_meas #(.FILT_CYC(F), .WIN_W(8), .STALL_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cadence_raw  (cadence_raw),
    .cadence_rise (cadence_rise),
    .cadence      (cadence),
    .not_pedaling (not_pedaling)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [4:0] exp_q[$];
  int         rise_q[$];
  int         np_q[$];
  bit         wave[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [4:0] cur_cad = '0;
  logic       last_np = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: stamps are the posedge count since reset release
  always @(negedge clk) begin : mon
    int e;
    if (mon_en && cyc != 0) begin
      if (cyc % WIN == 0) begin
        if (exp_q.size() == 0) check("cadence_unexpected_window", cyc, -1);
        else cur_cad = exp_q.pop_front();
      end
      check("cadence", cadence, cur_cad);
      if (cadence_rise) begin
        if (rise_q.size() == 0) check("rise_unexpected", cyc, -1);
        else check("rise_cycle", cyc, rise_q.pop_front());
      end
      if (not_pedaling !== last_np) begin
        last_np = not_pedaling;
        if (np_q.size() == 0) check("np_unexpected_edge", cyc, -1);
        else begin
          e = np_q.pop_front();
          check("np_edge_cycle", cyc, e / 2);
          check("np_edge_value", not_pedaling, e % 2);
        end
      end
    end
  end

  task automatic add(input bit lvl, input int len);
    repeat (len) wave.push_back(lvl);
  endtask

  task automatic pulses(input int cnt, input int hi, input int lo);
    repeat (cnt) begin
      add(1'b1, hi);
      add(1'b0, lo);
    end
  endtask

  // Predict from runs of the raw waveform, then drive it for T cycles and reset mid-activity.
  task automatic run_phase(input int T);
    int         rises[$];
    int         a, n, cnt, nxt, st;
    bit         filt, lvl;
    logic [4:0] cad_m;
    while (wave.size() < T + 1) wave.push_back(1'b0);
    filt = 1'b0;
    a = 0;
    while (a < T) begin
      lvl = wave[a];
      n = 0;
      while (a + n < T && wave[a + n] == lvl) n++;
      if (lvl != filt && n >= F) begin
        filt = lvl;
        if (lvl && a + F + 2 <= T) rises.push_back(a + F + 2);
      end
      a += n;
    end
    foreach (rises[i]) rise_q.push_back(rises[i]);
    cad_m = '0;
    for (int w = 0; WIN * (w + 1) <= T; w++) begin
      cnt = 0;
      foreach (rises[i]) if (rises[i] >= WIN * w && rises[i] < WIN * (w + 1)) cnt++;
      if (cnt > 31) cnt = 31;
`ifdef CADENCE_IIR_EN
      cad_m = 5'((3 * int'(cad_m) + cnt) / 4);
`else
      cad_m = 5'(cnt);
`endif
      exp_q.push_back(cad_m);
    end
    st = 1;
    foreach (rises[i]) begin
      if (st == 1) begin
        if (rises[i] + 1 <= T) np_q.push_back((rises[i] + 1) * 2);
        st = 0;
      end
      nxt = (i + 1 < rises.size()) ? rises[i + 1] : (1 << 30);
      if (nxt >= rises[i] + STALL_CYC && rises[i] + STALL_CYC <= T) begin
        np_q.push_back((rises[i] + STALL_CYC) * 2 + 1);
        st = 1;
      end
    end

    @(negedge clk);
    rst_n   = 1'b1;
    cur_cad = '0;
    last_np = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < T; i++) begin
      cadence_raw = wave[i];
      @(negedge clk);
    end
    #1;
    mon_en = 1'b0;
    check("leftover_cadence_windows", exp_q.size(), 0);
    check("leftover_rises", rise_q.size(), 0);
    check("leftover_np_edges", np_q.size(), 0);
    cadence_raw = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_cadence", cadence, 0);
    check("reset_not_pedaling", not_pedaling, 1);
    check("reset_cadence_rise", cadence_rise, 0);
    exp_q.delete();
    rise_q.delete();
    np_q.delete();
    wave.delete();
    repeat (3) @(negedge clk);
    cadence_raw = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cadence_raw = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("por_cadence", cadence, 0);
    check("por_not_pedaling", not_pedaling, 1);
    check("por_cadence_rise", cadence_rise, 0);

    // Glitch, single clean pulse, 5 clean pulses, a rise landing on a terminal cycle, random tail
    add(1'b0, 10); add(1'b1, 3); add(1'b0, 20); add(1'b1, 10); add(1'b0, 20);
    pulses(5, 20, 20);
    add(1'b0, 505 - wave.size());
    add(1'b1, 10); add(1'b0, 45);
    while (wave.size() < 900) begin
      add(1'b1, $urandom_range(1, 12));
      add(1'b0, $urandom_range(1, 12));
    end
    run_phase(800);

    // Random widths including sub-threshold glitches
    while (wave.size() < 1400) begin
      add(1'b1, $urandom_range(1, 30));
      add(1'b0, $urandom_range(1, 30));
    end
    run_phase(1300);

    // Saturation: 32 rises per window
    pulses(80, 4, 4);
    run_phase(600);

    // Stall timeout, then a single pulse to recover
    add(1'b0, 20); pulses(3, 20, 20); add(1'b0, 1300); add(1'b1, 10); add(1'b0, 400);
    run_phase(1800);

    // Steady 8 rises per window
    pulses(60, 16, 16);
    run_phase(1800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
